// File: rtl/if_fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// master: fetch/decode side; slave: the queue itself.
interface if_fetch_queue_if;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_pc_4;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc_4;
  logic [31:0] out_instr;
  logic        out_ready;

  modport master (
    output in_valid, in_pc, in_pc_4, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_4, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_pc_4, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_pc_4, out_instr
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: holds {pc, pc_4, instr} between fetch and decode,
// drops all wrong-path entries on a redirect flush.
module if_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_fetch_queue_if.slave      q,
  output logic [CW-1:0]        count,
  output logic [15:0]          flushed_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push;
  logic          pop;
  logic [16:0]   flushed_sum;
  logic [95:0]   head;

  assign q.in_ready  = (count != CW'(DEPTH));
  // Gated by flush so decode never consumes a wrong-path entry in the redirect cycle.
  assign q.out_valid = (count != '0) & ~q.flush;

  assign push = q.in_valid & q.in_ready & ~q.flush;
  assign pop  = q.out_valid & q.out_ready;

  assign head        = mem[rd_ptr];
  assign q.out_pc    = head[95:64];
  assign q.out_pc_4  = head[63:32];
  assign q.out_instr = head[31:0];

  assign flushed_sum = {1'b0, flushed_cnt} + 17'(count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      flushed_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (q.flush) begin
      // Storage is left intact; only pointers and occupancy are discarded.
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      flushed_cnt <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
    end else begin
      if (push) begin
        mem[wr_ptr] <= {q.in_pc, q.in_pc_4, q.in_instr};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue.
module tb_if_fetch_queue;
  logic        clk;
  logic        rst_n;
  logic [2:0]  count;
  logic [15:0] flushed_cnt;
  int          checks;
  int          errors;

  if_fetch_queue_if fq ();

  if_fetch_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q           (fq.slave),
    .count       (count),
    .flushed_cnt (flushed_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic rdy);
    fq.in_valid  = v;
    fq.in_pc     = pc;
    fq.in_pc_4   = pc + 32'd4;
    fq.in_instr  = {16'h1300, pc[15:0]};
    fq.flush     = fl;
    fq.out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(fq.out_valid), 32'd0);
    chk("rst_in_ready", 32'(fq.in_ready), 32'd1);
    chk("rst_out_pc", fq.out_pc, 32'h0);
    chk("rst_flushed", 32'(flushed_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // Stream 0x0..0x3C with decode always ready; head lags push by one cycle.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b1);
      if (i == 0) begin
        chk("stream_no_bypass", 32'(fq.out_valid), 32'd0);
      end else begin
        chk("stream_valid", 32'(fq.out_valid), 32'd1);
        chk("stream_pc", fq.out_pc, 32'(4 * (i - 1)));
        chk("stream_pc_4", fq.out_pc_4, 32'(4 * i));
        chk("stream_count", 32'(count), 32'd1);
      end
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stream_last_pc", fq.out_pc, 32'h3C);
    chk("stream_last_instr", fq.out_instr, 32'h1300_003C);
    tick();
    chk("stream_drained", 32'(count), 32'd0);
    chk("stream_drained_valid", 32'(fq.out_valid), 32'd0);

    // Fill under stall.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
      chk("fill_in_ready", 32'(fq.in_ready), 32'd1);
      tick();
    end
    drive(1'b1, 32'h110, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(fq.in_ready), 32'd0);
    chk("full_head", fq.out_pc, 32'h100);
    tick();
    chk("full_hold", 32'(count), 32'd4);
    // Pop at full with a pending fetch: no push may be accepted this cycle.
    drive(1'b1, 32'h110, 1'b0, 1'b1);
    chk("rel_head0", fq.out_pc, 32'h100);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rel_count", 32'(count), 32'd3);
    chk("rel_in_ready", 32'(fq.in_ready), 32'd1);
    chk("rel_head1", fq.out_pc, 32'h104);
    tick();
    chk("rel_head2", fq.out_pc, 32'h108);
    tick();
    chk("rel_head3", fq.out_pc, 32'h10C);
    tick();
    chk("rel_empty", 32'(count), 32'd0);
    chk("rel_empty_valid", 32'(fq.out_valid), 32'd0);

    // Flush with three queued entries and a same-cycle fetch.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h20, 1'b1, 1'b1);
    chk("flush_pre_count", 32'(count), 32'd3);
    chk("flush_out_valid", 32'(fq.out_valid), 32'd0);
    tick();
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_cnt3", 32'(flushed_cnt), 32'd3);
    chk("flush_in_ready", 32'(fq.in_ready), 32'd1);
    chk("flush_no_wrong_path", 32'(fq.out_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("redirect_valid", 32'(fq.out_valid), 32'd1);
    chk("redirect_pc", fq.out_pc, 32'h80);
    chk("redirect_count", 32'(count), 32'd1);
    tick();

    // Simultaneous push/pop at count=2.
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h304, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h308, 1'b0, 1'b1);
    chk("pp_count_a", 32'(count), 32'd2);
    chk("pp_head_a", fq.out_pc, 32'h300);
    tick();
    drive(1'b1, 32'h30C, 1'b0, 1'b1);
    chk("pp_count_b", 32'(count), 32'd2);
    chk("pp_head_b", fq.out_pc, 32'h304);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk("pp_count_c", 32'(count), 32'd2);
    chk("pp_head_c", fq.out_pc, 32'h308);
    tick();
    chk("pp_head_d", fq.out_pc, 32'h30C);
    tick();
    chk("pp_empty", 32'(count), 32'd0);

    // Flush and pop together at count=1: pop is ignored.
    drive(1'b1, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    chk("fp_out_valid", 32'(fq.out_valid), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("fp_count", 32'(count), 32'd0);
    chk("fp_flushed", 32'(flushed_cnt), 32'd4);

    // Empty flush adds nothing.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("empty_flush", 32'(flushed_cnt), 32'd4);

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("mid_pre_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_valid", 32'(fq.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(fq.in_ready), 32'd1);
    chk("mid_rst_pc", fq.out_pc, 32'h0);
    chk("mid_rst_flushed", 32'(flushed_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Saturation: 16383 flushes of 4 plus one of 2 gives 0xFFFE.
    for (int n = 0; n < 16383; n++) begin
      drive(1'b1, 32'h600, 1'b0, 1'b0);
      repeat (4) tick();
      drive(1'b1, 32'h600, 1'b1, 1'b0);
      tick();
    end
    drive(1'b1, 32'h600, 1'b0, 1'b0);
    repeat (2) tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("sat_fffe", 32'(flushed_cnt), 32'h0000_FFFE);
    for (int n = 0; n < 2; n++) begin
      drive(1'b1, 32'h700, 1'b0, 1'b0);
      repeat (4) tick();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      chk("sat_ffff", 32'(flushed_cnt), 32'h0000_FFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
